// File: rtl/seq_pkg.sv
// Shared definitions for the 1001 pattern generator, its detector and benches.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] PATTERN     = 4'b1001;
    localparam int         PATTERN_LEN = 4;

    // True when the last PATTERN_LEN-1 bits followed by nxt form PATTERN.
    function automatic logic pattern_hit(input logic [PATTERN_LEN-2:0] hist,
                                         input logic                   nxt);
        return ({hist, nxt} == PATTERN);
    endfunction

endpackage

// File: rtl/seq_1001_gen_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a coincident increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_1001_gen.sv
// Serializes handshaked words MSB-first onto a registered bit stream and flags
// every cycle in which that stream completes a 1001 pattern.
module seq_1001_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out,
    output logic             out_valid,
    output logic             exp_det,
    output logic [CNT_W-1:0] det_count,
    input  logic             clr_count
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_shreg;
    logic [WIDTH-1:0]    w_shreg_nxt;
    logic [CW-1:0]       r_bit_cnt;
    logic [CW-1:0]       w_bit_cnt_nxt;
    logic                r_out;
    logic                w_out_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic [PATTERN_LEN-2:0] r_hist;
    logic                r_exp_det;
    logic                w_accept;
    logic                w_ready;

    // Ready on the last-bit cycle as well, so words can stream without a gap.
    assign w_ready  = (r_state == IDLE) || (r_bit_cnt == '0);
    assign w_accept = load_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_out_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;
        if (w_accept) begin
            w_state_nxt     = SHIFT;
            w_out_nxt       = load_data[WIDTH-1];
            w_out_valid_nxt = 1'b1;
            w_shreg_nxt     = {load_data[WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt   = CW'(WIDTH - 1);
        end else if ((r_state == SHIFT) && (r_bit_cnt != '0)) begin
            w_out_nxt       = r_shreg[WIDTH-1];
            w_out_valid_nxt = 1'b1;
            w_shreg_nxt     = {r_shreg[WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt   = r_bit_cnt - CW'(1);
        end else begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
        end
    end

    // Tracks the value about to appear on out, idle zeros included, so the
    // pulse lines up with the cycle that shows the completing 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_exp_det <= 1'b0;
        end else begin
            r_exp_det <= pattern_hit(r_hist, w_out_nxt);
            r_hist    <= {r_hist[PATTERN_LEN-3:0], w_out_nxt};
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_det_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_exp_det),
        .clr   (clr_count),
        .count (det_count)
    );

    assign load_ready = w_ready;
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign exp_det    = r_exp_det;

endmodule

// File: tb/tb_seq_1001_gen.sv
// Directed bench: bits are queued when a word is accepted and popped as the
// stream advances; a reference tracker predicts pulses and both counters.
module tb_seq_1001_gen;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        clr_count;
    logic        load_ready, out, out_valid, exp_det;
    logic [15:0] det_count;
    logic        ready2, out2, valid2, det2;
    logic [1:0]  det_count2;

    int n_checks = 0;
    int n_fail   = 0;

    logic        q[$];
    logic [2:0]  m_hist;
    logic        m_det;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    always #5 clk = ~clk;

    seq_1001_gen #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .out(out), .out_valid(out_valid), .exp_det(exp_det),
        .det_count(det_count), .clr_count(clr_count)
    );

    seq_1001_gen #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready2),
        .load_data(load_data), .out(out2), .out_valid(valid2), .exp_det(det2),
        .det_count(det_count2), .clr_count(clr_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_hist = 3'b000;
        m_det  = 1'b0;
        m_cnt  = 16'd0;
        m_cnt2 = 2'd0;
    endtask

    task automatic check_outputs(input string tag);
        logic e_out;
        e_out = (q.size() != 0) ? q[0] : 1'b0;
        chk({tag, ".out"},       {15'd0, out},        {15'd0, e_out});
        chk({tag, ".out_valid"}, {15'd0, out_valid},  {15'd0, (q.size() != 0)});
        chk({tag, ".exp_det"},   {15'd0, exp_det},    {15'd0, m_det});
        chk({tag, ".det_count"}, det_count,           m_cnt);
        chk({tag, ".det_count2"},{14'd0, det_count2}, {14'd0, m_cnt2});
    endtask

    // One clock: drive inputs mid-cycle, advance the model at the edge,
    // compare at the following falling edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic clr);
        logic acc, e_rdy, nxt;
        load_valid = v;
        load_data  = d;
        clr_count  = clr;
        #1;
        e_rdy = (q.size() <= 1);
        chk({tag, ".ready"}, {15'd0, load_ready}, {15'd0, e_rdy});
        acc = v && e_rdy;
        @(posedge clk);
        if (clr) begin
            m_cnt  = 16'd0;
            m_cnt2 = 2'd0;
        end else if (m_det) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            if (m_cnt2 != 2'b11)   m_cnt2++;
        end
        if (q.size() != 0) void'(q.pop_front());
        if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
        nxt    = (q.size() != 0) ? q[0] : 1'b0;
        m_det  = ({m_hist, nxt} == PATTERN);
        m_hist = {m_hist[1:0], nxt};
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        clr_count  = 1'b0;
        #1;
        model_clear();
        chk("rst.out",       {15'd0, out},       16'd0);
        chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst.exp_det",   {15'd0, exp_det},   16'd0);
        chk("rst.det_count", det_count,          16'd0);
        chk("rst.ready",     {15'd0, load_ready},16'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        clr_count  = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single word: pulses on bits 4 and 7
        step("single", 1'b1, 8'b1001_0010, 1'b0);
        idle("single", 9);
        chk("single.total", det_count, 16'd2);

        // Back-to-back: B accepted on A's last bit, 100|1 across the boundary
        do_reset();
        step("b2b", 1'b1, 8'b0000_0100, 1'b0);
        for (int i = 0; i < 8; i++) step("b2b", 1'b1, 8'b1000_0000, 1'b0);
        idle("b2b", 9);
        chk("b2b.total", det_count, 16'd1);

        // One idle zero: 1,0,1 is not a match
        do_reset();
        step("gap1", 1'b1, 8'b0000_0001, 1'b0);
        idle("gap1", 8);
        step("gap1", 1'b1, 8'b1000_0000, 1'b0);
        idle("gap1", 9);
        chk("gap1.total", det_count, 16'd0);

        // Two idle zeros: 1,0,0,1 matches on B's first bit
        do_reset();
        step("gap2", 1'b1, 8'b0000_0001, 1'b0);
        idle("gap2", 9);
        step("gap2", 1'b1, 8'b1000_0000, 1'b0);
        chk("gap2.first_bit_det", {15'd0, exp_det}, 16'd1);
        idle("gap2", 9);
        chk("gap2.total", det_count, 16'd1);

        // Saturation on the 2-bit instance, then clear coinciding with a pulse
        do_reset();
        step("sat", 1'b1, 8'b1001_1001, 1'b0);
        idle("sat", 7);
        step("sat", 1'b1, 8'b1001_1001, 1'b0);
        idle("sat", 9);
        chk("sat.cnt2", {14'd0, det_count2}, 16'd3);
        chk("sat.cnt16", det_count, 16'd4);
        step("clr", 1'b1, 8'b1001_0000, 1'b0);
        idle("clr", 3);
        chk("clr.pulse", {15'd0, exp_det}, 16'd1);
        step("clr", 1'b0, 8'h00, 1'b1);
        chk("clr.cnt16", det_count, 16'd0);
        chk("clr.cnt2", {14'd0, det_count2}, 16'd0);
        idle("clr", 6);

        // Reset during the third bit of a word, then no leftover history
        do_reset();
        step("midrst", 1'b1, 8'b1111_0000, 1'b0);
        idle("midrst", 2);
        #2;
        do_reset();
        step("postrst", 1'b1, 8'b1001_0000, 1'b0);
        idle("postrst", 9);
        chk("postrst.total", det_count, 16'd1);

        // Hold-off: only the data on the last-bit cycle is taken
        do_reset();
        step("hold", 1'b1, 8'hA5, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            logic [7:0] junk;
            junk = 8'(8'h11 * i);
            step("hold", 1'b1, junk, 1'b0);
        end
        step("hold", 1'b1, 8'b1001_0110, 1'b0);
        idle("hold", 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_1001_gen.md
Name: seq_1001_gen

Overview:
- Serial pattern transmitter: the driving end of the 1001 sequence detector's single-bit interface.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a continuous `out` stream. The stream idles at 0 between words.
- Independently flags every cycle in which the emitted stream completes a 1001 pattern, overlaps allowed. Benches and self-checking systems compare this against the detector's `out`.

Parameters:
- WIDTH, 8, bits per loaded word; legal values are 2 or more.
- CNT_W, 16, width of the saturating detection counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word this cycle
- load_data  input  WIDTH  word to serialize, MSB sent first
- out  output  1  serial bit stream, registered; 0 when idle
- out_valid  output  1  `out` carries a word bit this cycle
- exp_det  output  1  1-cycle pulse: {previous three out bits, current out} == 4'b1001
- det_count  output  CNT_W  number of exp_det pulses, saturating
- clr_count  input  1  synchronous clear of det_count

Behaviour:
- Reset (async, any time, including mid-word):
  - state=IDLE; out=0, out_valid=0, exp_det=0, det_count=0.
  - History hist[2:0]=000, shift register and bit counter cleared.
  - Any partially sent word is discarded. load_ready=1 as soon as rst is high.
- States: IDLE and SHIFT.
- load_ready is combinational: 1 in IDLE, or in SHIFT when bit_cnt==0 (last bit on `out`). It is 0 otherwise and never depends on load_valid.
- Accept = load_valid & load_ready at a rising edge. At that edge:
  - out <= load_data[WIDTH-1]; out_valid <= 1.
  - shreg <= load_data shifted left by 1; bit_cnt <= WIDTH-1.
  - state <= SHIFT.
  - Latency: first bit is visible the cycle after accept.
- SHIFT with bit_cnt != 0: out <= shreg MSB, shreg shifts left, bit_cnt decrements. Each word occupies exactly WIDTH consecutive cycles of out_valid=1.
- SHIFT with bit_cnt==0:
  - With accept: back-to-back load, no gap; out_valid stays 1.
  - Without accept: out <= 0, out_valid <= 0, state <= IDLE.
- IDLE without accept: out stays 0 and out_valid stays 0.
- Pattern tracking runs every cycle on `out`, whether or not out_valid is high, so idle zeros count exactly as a downstream detector sees them. At each edge, where nxt is the value being loaded into `out`:
  - exp_det <= ({hist, nxt} == 4'b1001)
  - hist <= {hist[1:0], nxt}
  - As a result, exp_det is high in the same cycle that `out` shows the completing 1.
- Overlap: stream 1001001 produces two pulses. Patterns spanning word boundaries and idle gaps are detected.
- det_count update at each edge:
  - clr_count=1: det_count <= 0. Clear has priority over a simultaneous exp_det.
  - Else if exp_det=1 and det_count != all-ones: increment.
  - At all-ones, det_count holds.
- load_data is sampled only at accept; changes at other times are ignored.

Decomposition:
- Shared package `seq_pkg`:
  - State enum {IDLE, SHIFT}.
  - Constants PATTERN = 4'b1001 and PATTERN_LEN = 4, also used by the detector and benches.
- One natural sub-module: `sat_counter` (CNT_W, inc, clr, count) for det_count, reusable by the detector's bench scoreboard.
- Shifter and FSM stay in `seq_1001_gen`.

Test Plan (all scenarios use WIDTH=8):
- Single word: after reset, accept 8'b1001_0010.
  - `out` shows 1,0,0,1,0,0,1,0 on the 8 cycles after accept, with out_valid=1 throughout.
  - exp_det pulses on bits 4 and 7.
  - det_count=2; then out=0, out_valid=0, state IDLE.
- Back-to-back: hold load_valid with A=8'b0000_0100, then B=8'b1000_0000.
  - B is accepted on A's last-bit cycle; 16 contiguous out_valid cycles.
  - Exactly one exp_det, on B's first bit (boundary 100|1); det_count=1.
- Idle gap: accept 8'b0000_0001, then accept 8'b1000_0000 two cycles after A's last bit.
  - Exactly one idle 0 cycle.
  - Stream 1,0,1 gives no detection; det_count=0.
  - Repeat with B accepted one cycle later (two idle zeros): exp_det on B's first bit, det_count=1.
- Saturation and clear: CNT_W=2, send 8'b1001_1001 twice.
  - Four pulses; det_count stops at 3.
  - Assert clr_count in the same cycle as an exp_det pulse: det_count=0 the next cycle.
- Reset mid-word: accept 8'b1111_0000, assert rst during the 3rd bit.
  - Immediately out=0, out_valid=0, exp_det=0, det_count=0, load_ready=1.
  - After release, a new word 8'b1001_0000 yields exactly one exp_det, with no leftover history.
- Handshake hold-off: keep load_valid=1 with a changing load_data during bits 1–7 of a word.
  - load_ready=0 on those cycles.
  - Only the value present on the last-bit cycle is accepted.
